// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: pops bytes from the UART RX FIFO and parses framed commands
// (0xA5, CMD, LEN, payload, CSUM). Valid frames are executed as a START pulse
// or as a config-register write over a valid/ready handshake. Bad or stalled
// frames are dropped and flagged on frame_err/err_code.
module uart_cmd_parser #(
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned MAX_LEN        = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_uart_data_fifo,
   input  logic        rx_uart_valid_fifo,
   output logic        rx_uart_ready_fifo,
   output logic        start_write_frame,
   output logic        cfg_valid,
   input  logic        cfg_ready,
   output logic [7:0]  cfg_addr,
   output logic [15:0] cfg_data,
   output logic        frame_err,
   output logic [1:0]  err_code,
   output logic        busy
);

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned IDX_W     = 2;
   localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYCLES);

   localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;
   localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h01;
   localparam logic [BYTE_W-1:0] CMD_START = 8'h02;
   localparam logic [BYTE_W-1:0] WRITE_LEN = 8'd3;
   localparam logic [BYTE_W-1:0] START_LEN = 8'd0;
   localparam logic [BYTE_W-1:0] LEN_LIMIT = BYTE_W'(MAX_LEN);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ERR_CSUM    = 2'd0;
   localparam logic [1:0] ERR_CMD     = 2'd1;
   localparam logic [1:0] ERR_LEN     = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_LEN,
      S_PAYLOAD,
      S_CSUM,
      S_EXEC,
      S_CFG_WAIT
   } state_e;

   state_e              state_q, state_d;
   logic [BYTE_W-1:0]   cmd_q, cmd_d;
   logic [BYTE_W-1:0]   len_q, len_d;
   logic [BYTE_W-1:0]   sum_q, sum_d;
   logic [BYTE_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]    pidx_q, pidx_d;
   logic [ADDR_W-1:0]   pl_addr_q, pl_addr_d;
   logic [DATA_W-1:0]   pl_data_q, pl_data_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                start_q, start_d;
   logic                cfg_valid_q, cfg_valid_d;
   logic [ADDR_W-1:0]   cfg_addr_q, cfg_addr_d;
   logic [DATA_W-1:0]   cfg_data_q, cfg_data_d;
   logic                frame_err_q, frame_err_d;
   logic [1:0]          err_code_q, err_code_d;
   logic                busy_q, busy_d;

   logic                accept_c;
   logic                counting_c;
   logic                timeout_c;

   // FIFO ready is decoded straight from state: parser takes bytes in all framing states
   always_comb begin
      rx_uart_ready_fifo = (state_q == S_IDLE) || (state_q == S_CMD) ||
                           (state_q == S_LEN)  || (state_q == S_PAYLOAD) ||
                           (state_q == S_CSUM);
   end

   assign accept_c          = rx_uart_valid_fifo && rx_uart_ready_fifo;
   assign counting_c        = (state_q == S_CMD) || (state_q == S_LEN) ||
                              (state_q == S_PAYLOAD) || (state_q == S_CSUM);

   assign start_write_frame = start_q;
   assign cfg_valid         = cfg_valid_q;
   assign cfg_addr          = cfg_addr_q;
   assign cfg_data          = cfg_data_q;
   assign frame_err         = frame_err_q;
   assign err_code          = err_code_q;
   assign busy              = busy_q;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      len_d       = len_q;
      sum_d       = sum_q;
      cnt_d       = cnt_q;
      pidx_d      = pidx_q;
      pl_addr_d   = pl_addr_q;
      pl_data_d   = pl_data_q;
      tmo_d       = '0;
      start_d     = 1'b0;
      cfg_valid_d = cfg_valid_q;
      cfg_addr_d  = cfg_addr_q;
      cfg_data_d  = cfg_data_q;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;
      timeout_c   = 1'b0;

      // Inter-byte timer: a byte in the expiry cycle takes priority over the timeout
      if (counting_c) begin
         if (accept_c) begin
            tmo_d = '0;
         end else if (tmo_q == TMO_LAST) begin
            timeout_c = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (accept_c && (rx_uart_data_fifo == SYNC_BYTE)) begin
               state_d = S_CMD;
            end
         end
         S_CMD: begin
            if (accept_c) begin
               cmd_d   = rx_uart_data_fifo;
               sum_d   = rx_uart_data_fifo;
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (accept_c) begin
               if (rx_uart_data_fifo > LEN_LIMIT) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_LEN;
                  state_d     = S_IDLE;
               end else begin
                  sum_d   = sum_q + rx_uart_data_fifo;
                  len_d   = rx_uart_data_fifo;
                  cnt_d   = rx_uart_data_fifo;
                  pidx_d  = '0;
                  state_d = (rx_uart_data_fifo == 8'd0) ? S_CSUM : S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (accept_c) begin
               sum_d = sum_q + rx_uart_data_fifo;
               case (pidx_q)
                  2'd0:    pl_addr_d        = rx_uart_data_fifo;
                  2'd1:    pl_data_d[15:8]  = rx_uart_data_fifo;
                  2'd2:    pl_data_d[7:0]   = rx_uart_data_fifo;
                  default: ;
               endcase
               if (pidx_q != 2'd3) begin
                  pidx_d = pidx_q + 2'd1;
               end
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  state_d = S_CSUM;
               end
            end
         end
         S_CSUM: begin
            if (accept_c) begin
               if (rx_uart_data_fifo != sum_q) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_CSUM;
                  state_d     = S_IDLE;
               end else if ((cmd_q != CMD_WRITE) && (cmd_q != CMD_START)) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_CMD;
                  state_d     = S_IDLE;
               end else if (((cmd_q == CMD_WRITE) && (len_q != WRITE_LEN)) ||
                            ((cmd_q == CMD_START) && (len_q != START_LEN))) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_LEN;
                  state_d     = S_IDLE;
               end else begin
                  if (cmd_q == CMD_WRITE) begin
                     cfg_valid_d = 1'b1;
                     cfg_addr_d  = pl_addr_q;
                     cfg_data_d  = pl_data_q;
                  end else begin
                     start_d = 1'b1;
                  end
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            // A handshake already in this cycle completes the write here
            if (cmd_q == CMD_WRITE) begin
               if (cfg_ready) begin
                  cfg_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end else begin
                  state_d = S_CFG_WAIT;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CFG_WAIT: begin
            if (cfg_ready) begin
               cfg_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (timeout_c) begin
         frame_err_d = 1'b1;
         err_code_d  = ERR_TIMEOUT;
         state_d     = S_IDLE;
      end

      busy_d = (state_d != S_IDLE);
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Frame datapath and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmd_q       <= '0;
         len_q       <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         pidx_q      <= '0;
         pl_addr_q   <= '0;
         pl_data_q   <= '0;
         tmo_q       <= '0;
         start_q     <= 1'b0;
         cfg_valid_q <= 1'b0;
         cfg_addr_q  <= '0;
         cfg_data_q  <= '0;
         frame_err_q <= 1'b0;
         err_code_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         cmd_q       <= cmd_d;
         len_q       <= len_d;
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         pidx_q      <= pidx_d;
         pl_addr_q   <= pl_addr_d;
         pl_data_q   <= pl_data_d;
         tmo_q       <= tmo_d;
         start_q     <= start_d;
         cfg_valid_q <= cfg_valid_d;
         cfg_addr_q  <= cfg_addr_d;
         cfg_data_q  <= cfg_data_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
         busy_q      <= busy_d;
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with TIMEOUT_CYCLES = 16, MAX_LEN = 8.
module tb_uart_cmd_parser;

   logic        clk;
   logic        rst;
   logic [7:0]  rx_uart_data_fifo;
   logic        rx_uart_valid_fifo;
   logic        rx_uart_ready_fifo;
   logic        start_write_frame;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [7:0]  cfg_addr;
   logic [15:0] cfg_data;
   logic        frame_err;
   logic [1:0]  err_code;
   logic        busy;

   int tests_run    = 0;
   int tests_failed = 0;
   int start_cnt    = 0;
   int wr_cnt       = 0;
   int err_cnt      = 0;

   uart_cmd_parser #(
      .TIMEOUT_CYCLES (16),
      .MAX_LEN        (8)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .rx_uart_data_fifo  (rx_uart_data_fifo),
      .rx_uart_valid_fifo (rx_uart_valid_fifo),
      .rx_uart_ready_fifo (rx_uart_ready_fifo),
      .start_write_frame  (start_write_frame),
      .cfg_valid          (cfg_valid),
      .cfg_ready          (cfg_ready),
      .cfg_addr           (cfg_addr),
      .cfg_data           (cfg_data),
      .frame_err          (frame_err),
      .err_code           (err_code),
      .busy               (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Event counters for pulses and completed config writes
   always @(posedge clk) begin
      if (start_write_frame)     start_cnt <= start_cnt + 1;
      if (cfg_valid && cfg_ready) wr_cnt   <= wr_cnt + 1;
      if (frame_err)             err_cnt   <= err_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one byte and return #1 after the edge that transfers it
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_uart_data_fifo  = b;
      rx_uart_valid_fifo = 1'b1;
      while (!rx_uart_ready_fifo && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("ready_wait_timeout", 32'(n), 32'(0));
      tick();
      rx_uart_valid_fifo = 1'b0;
   endtask

   initial begin
      rst                = 1'b0;
      rx_uart_data_fifo  = 8'h00;
      rx_uart_valid_fifo = 1'b0;
      cfg_ready          = 1'b0;
      tick();
      tick();

      // Reset values
      chk("rst_ready",     32'(rx_uart_ready_fifo), 32'(1));
      chk("rst_start",     32'(start_write_frame),  32'(0));
      chk("rst_cfg_valid", 32'(cfg_valid),          32'(0));
      chk("rst_frame_err", 32'(frame_err),          32'(0));
      chk("rst_busy",      32'(busy),               32'(0));
      chk("rst_err_code",  32'(err_code),           32'(0));
      chk("rst_cfg_addr",  32'(cfg_addr),           32'(0));
      chk("rst_cfg_data",  32'(cfg_data),           32'(0));
      rst = 1'b1;
      tick();

      // START frame: A5 02 00 02
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
      chk("start_pulse",      32'(start_write_frame),  32'(1));
      chk("start_no_err",     32'(frame_err),          32'(0));
      chk("start_busy_exec",  32'(busy),               32'(1));
      chk("start_ready_exec", 32'(rx_uart_ready_fifo), 32'(0));
      tick();
      chk("start_pulse_end",  32'(start_write_frame),  32'(0));
      chk("start_busy_low",   32'(busy),               32'(0));
      chk("start_ready_back", 32'(rx_uart_ready_fifo), 32'(1));
      chk("start_count_1",    32'(start_cnt),          32'(1));

      // WRITE_REG with back-pressure: A5 01 03 10 12 34 5A
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03);
      send_byte(8'h10); send_byte(8'h12); send_byte(8'h34); send_byte(8'h5A);
      chk("wr_valid_rise", 32'(cfg_valid),          32'(1));
      chk("wr_addr",       32'(cfg_addr),           32'(8'h10));
      chk("wr_data",       32'(cfg_data),           32'(16'h1234));
      chk("wr_ready_low",  32'(rx_uart_ready_fifo), 32'(0));
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("wr_hold_valid", 32'(cfg_valid),          32'(1));
         chk("wr_hold_addr",  32'(cfg_addr),           32'(8'h10));
         chk("wr_hold_data",  32'(cfg_data),           32'(16'h1234));
         chk("wr_hold_ready", 32'(rx_uart_ready_fifo), 32'(0));
      end
      cfg_ready = 1'b1;
      tick();
      cfg_ready = 1'b0;
      chk("wr_valid_drop", 32'(cfg_valid),          32'(0));
      chk("wr_ready_back", 32'(rx_uart_ready_fifo), 32'(1));
      chk("wr_busy_low",   32'(busy),               32'(0));
      chk("wr_count_1",    32'(wr_cnt),             32'(1));

      // Bad checksum: A5 02 00 03
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h03);
      chk("csum_err",      32'(frame_err),         32'(1));
      chk("csum_code",     32'(err_code),          32'(0));
      chk("csum_no_start", 32'(start_write_frame), 32'(0));
      tick();
      chk("csum_err_pulse", 32'(frame_err), 32'(0));

      // Good START right after the dropped frame
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
      chk("start2_pulse", 32'(start_write_frame), 32'(1));
      chk("start2_no_err", 32'(frame_err),        32'(0));
      tick();

      // LEN above MAX_LEN rejected as soon as LEN is accepted: A5 01 09
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h09);
      chk("maxlen_err",  32'(frame_err), 32'(1));
      chk("maxlen_code", 32'(err_code),  32'(2));
      chk("maxlen_idle", 32'(busy),      32'(0));

      // Unknown command: A5 07 00 07
      send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
      chk("cmd_err",  32'(frame_err), 32'(1));
      chk("cmd_code", 32'(err_code),  32'(1));

      // START with wrong length: A5 02 01 55 58
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h55); send_byte(8'h58);
      chk("len_err",      32'(frame_err),         32'(1));
      chk("len_code",     32'(err_code),          32'(2));
      chk("len_no_start", 32'(start_write_frame), 32'(0));
      tick();
      chk("len_code_hold", 32'(err_code), 32'(2));

      // Timeout: A5 01 then idle, error 16 cycles after the last byte
      send_byte(8'hA5); send_byte(8'h01);
      for (int i = 0; i < 15; i++) begin
         tick();
         chk("tmo_not_yet", 32'(frame_err), 32'(0));
      end
      tick();
      chk("tmo_err",  32'(frame_err), 32'(1));
      chk("tmo_code", 32'(err_code),  32'(3));
      chk("tmo_idle", 32'(busy),      32'(0));
      tick();
      chk("tmo_pulse_end", 32'(frame_err), 32'(0));

      // Byte arriving in the expiry cycle wins: A5 01, 15 idle cycles, 03 20 AB CD 9C
      send_byte(8'hA5); send_byte(8'h01);
      for (int i = 0; i < 15; i++) tick();
      send_byte(8'h03);
      chk("tmo_byte_wins", 32'(frame_err), 32'(0));
      chk("tmo_byte_busy", 32'(busy),      32'(1));
      send_byte(8'h20); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h9C);
      chk("wr2_valid", 32'(cfg_valid), 32'(1));
      chk("wr2_addr",  32'(cfg_addr),  32'(8'h20));
      chk("wr2_data",  32'(cfg_data),  32'(16'hABCD));
      tick();
      cfg_ready = 1'b1;
      tick();
      cfg_ready = 1'b0;
      chk("wr2_valid_drop", 32'(cfg_valid), 32'(0));
      chk("wr2_count",      32'(wr_cnt),    32'(2));

      // Garbage in IDLE raises nothing
      send_byte(8'h00);
      chk("garbage0_err",  32'(frame_err), 32'(0));
      send_byte(8'hFF);
      chk("garbageff_err", 32'(frame_err), 32'(0));
      chk("garbage_busy",  32'(busy),      32'(0));
      chk("garbage_code",  32'(err_code),  32'(3));

      // Reset asserted while waiting in CFG_WAIT
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03);
      send_byte(8'h10); send_byte(8'h12); send_byte(8'h34); send_byte(8'h5A);
      tick();
      chk("rstmid_valid_before", 32'(cfg_valid), 32'(1));
      #2;
      rst = 1'b0;
      #1;
      chk("rstmid_valid_async", 32'(cfg_valid),          32'(0));
      chk("rstmid_ready",       32'(rx_uart_ready_fifo), 32'(1));
      chk("rstmid_busy",        32'(busy),               32'(0));
      chk("rstmid_addr",        32'(cfg_addr),           32'(0));
      chk("rstmid_code",        32'(err_code),           32'(0));
      tick();
      rst = 1'b1;
      tick();
      chk("rstmid_idle_after", 32'(busy), 32'(0));
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
      chk("rstmid_start_pulse", 32'(start_write_frame), 32'(1));
      tick();
      tick();

      chk("total_starts", 32'(start_cnt), 32'(3));
      chk("total_writes", 32'(wr_cnt),    32'(2));
      chk("total_errors", 32'(err_cnt),   32'(5));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
